if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode and the next-PC logic. Holds the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Delivers instructions into the IF/ID pipeline register with their pc and pc+4. Applies decode-stage stall and redirect (branch/jump target from the next-PC logic). No delay slot: a redirect flushes younger fetches.

Parameters:
RESET_PC, 32'h0000_3000, fetch PC after reset
DATA_W, 32, instruction and address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active low
stall  in  1  decode stalled; IF/ID must hold
redirect_valid  in  1  taken branch/jump/jr resolved in decode
redirect_pc  in  32  target from next-PC logic
imem_req  out  1  memory request; held until imem_ack
imem_addr  out  32  request word address; stable while imem_req=1
imem_ack  in  1  one-cycle strobe; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  instruction (0 = nop when invalid)
if_id_pc  out  32  address of if_id_instr
if_id_pc4  out  32  if_id_pc+4 (link value for jal)
if_id_adel  out  1  fetch address misaligned

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, req_addr=RESET_PC, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc4=0, if_id_adel=0, buffer empty.
- Registers: pc = next address to request; req_addr drives imem_addr; buf_instr = one-entry skid buffer (with buf_pc).
- States:
  - IDLE -> FETCH unconditionally on the first edge after reset release. imem_req=0.
  - FETCH: imem_req=1 when req_addr[1:0]==0. Misaligned address: imem_req=0, treated as an immediate ack with rdata=0 and adel=1.
  - KILL: imem_req=1 with the stale req_addr. The next ack is discarded, then req_addr<=pc and the state returns to FETCH.
  - FULL: imem_req=0. buf_instr is waiting for decode.
- FETCH, edge with ack:
  - redirect_valid: discard the data; pc<=req_addr<=redirect_pc; if_id_valid<=0.
  - else if !stall: IF/ID<={1, rdata, req_addr, req_addr+4, 0}; pc<=req_addr<=req_addr+4. One request per 1+latency cycles; back-to-back when ack arrives in the request cycle.
  - else (stall): buf<=rdata; pc<=req_addr+4; state->FULL; IF/ID held.
- FETCH, edge without ack:
  - redirect_valid: pc<=redirect_pc; state->KILL; if_id_valid<=0.
  - else if !stall: if_id_valid<=0 (bubble).
  - else: IF/ID held.
- KILL: a further redirect overwrites pc. if_id_valid stays 0 unless stalled.
- FULL:
  - redirect_valid: drop buf; req_addr<=pc<=redirect_pc; if_id_valid<=0; ->FETCH.
  - else if !stall: IF/ID<=buf; req_addr<=pc; ->FETCH.
  - else: hold.
- Priority: redirect > stall > capture. A redirect always clears if_id_valid on the next edge, even with stall=1.
- Arithmetic: pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 0.
- Misaligned pc keeps advancing by 4 (stays misaligned) until a redirect from exception logic.
- No state change while imem_req=1 may alter imem_addr except the ack edge.
- Reset mid-transaction abandons the request; a memory ack arriving during or after reset for it must be ignored (IDLE ignores ack).

Decomposition:
- Shared package mips_defs: RESET_PC constant, fetch state enum {IDLE, FETCH, KILL, FULL}, NOP=32'h0.
- One sub-module: if_id_reg, the IF/ID register with load/hold/clear controls.

Test Plan:
- Reset release, ack on the same cycle as each req, rdata=PC-tagged words -> if_id_pc 0x3000, 0x3004, 0x3008 on consecutive cycles; if_id_pc4=pc+4.
- 3-cycle ack latency -> imem_addr stable for 3 cycles; two bubbles (if_id_valid=0) between instructions.
- stall=1 when ack for 0x3008 arrives -> state FULL, imem_req=0, IF/ID holds 0x3004. Release -> IF/ID=0x3008 next edge, req 0x300C the cycle after.
- redirect_pc=0x3100 during an outstanding 0x3010 request -> KILL. Stale ack discarded; next req 0x3100; no instruction from 0x3010 enters IF/ID.
- redirect while FULL with stall=1 -> buf dropped; if_id_valid=0; next req 0x3100.
- redirect_pc=0x3102 -> imem_req=0; if_id_adel=1, instr=0, if_id_pc=0x3102. Then rst_n low mid-request -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared fetch-stage constants and state encoding
package mips_defs;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2,
        FULL  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and clear
module if_id_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic              adel_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic              adel_o
);
    import mips_defs::*;

    // An invalid entry always reads as a nop so decode never sees stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            instr_o <= NOP;
            pc_o    <= '0;
            pc4_o   <= '0;
            adel_o  <= 1'b0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
            instr_o <= NOP;
            pc_o    <= '0;
            pc4_o   <= '0;
            adel_o  <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            instr_o <= instr_i;
            pc_o    <= pc_i;
            pc4_o   <= pc4_i;
            adel_o  <= adel_i;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
module if_fetch_unit #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = mips_defs::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_pc4,
    output logic              if_id_adel
);
    import mips_defs::*;

    localparam logic [DATA_W-1:0] STEP = DATA_W'(4);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic [DATA_W-1:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;
    logic              buf_adel_q, buf_adel_d;

    logic              misaligned, fetch_ack;
    logic [DATA_W-1:0] fetch_data, req_next;
    logic              ifid_load, ifid_clear, ld_adel;
    logic [DATA_W-1:0] ld_instr, ld_pc;

    // A misaligned fetch never reaches memory; it completes at once as a nop tagged adel.
    assign misaligned = (req_addr_q[1:0] != 2'b00);
    assign fetch_ack  = misaligned || imem_ack;
    assign fetch_data = misaligned ? NOP : imem_rdata;
    assign req_next   = req_addr_q + STEP;
    assign imem_req   = ((state_q == FETCH) && !misaligned) || (state_q == KILL);
    assign imem_addr  = req_addr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_adel_d  = buf_adel_q;
        ifid_load   = 1'b0;
        ifid_clear  = 1'b0;
        ld_instr    = fetch_data;
        ld_pc       = req_addr_q;
        ld_adel     = misaligned;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    ifid_clear = 1'b1;
                    pc_d       = redirect_pc;
                    // imem_addr must not move under a live request, so wait out the stale ack.
                    if (fetch_ack) req_addr_d = redirect_pc;
                    else           state_d    = KILL;
                end else if (fetch_ack) begin
                    pc_d = req_next;
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        req_addr_d = req_next;
                    end else begin
                        buf_instr_d = fetch_data;
                        buf_pc_d    = req_addr_q;
                        buf_adel_d  = misaligned;
                        state_d     = FULL;
                    end
                end else if (!stall) begin
                    ifid_clear = 1'b1;
                end
            end
            KILL: begin
                if (redirect_valid) pc_d = redirect_pc;
                ifid_clear = redirect_valid || !stall;
                if (imem_ack) begin
                    req_addr_d = redirect_valid ? redirect_pc : pc_q;
                    state_d    = FETCH;
                end
            end
            FULL: begin
                ld_instr = buf_instr_q;
                ld_pc    = buf_pc_q;
                ld_adel  = buf_adel_q;
                if (redirect_valid) begin
                    ifid_clear = 1'b1;
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = FETCH;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_instr_q <= NOP;
            buf_pc_q    <= '0;
            buf_adel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_adel_q  <= buf_adel_d;
        end
    end

    if_id_reg #(.DATA_W(DATA_W)) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (ifid_clear),
        .load_i  (ifid_load),
        .instr_i (ld_instr),
        .pc_i    (ld_pc),
        .pc4_i   (ld_pc + STEP),
        .adel_i  (ld_adel),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4),
        .adel_o  (if_id_adel)
    );

endmodule
